// File: rtl/pipeline_skid_stage.sv
// pipeline_skid_stage
//   Elastic register stage for a processor pipeline. A one-entry skid buffer
//   sits behind the output register. in_ready comes from a flop, so backpressure
//   from downstream never forms a combinational path to upstream.
//   Flush squashes every held entry. A saturating counter records the
//   downstream stall cycles.
//
// Handshake: on either side, a payload moves on a rising clk edge only when
//   valid and ready are both 1 on that side. A producer holds valid and data
//   steady until that edge. While out_valid=1 and out_ready=0, out_data does not
//   change.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   flush        synchronous squash of all held entries and of any offered input
//   in_valid     upstream offers in_data
//   in_ready     stage can accept a payload (registered)
//   in_data      upstream payload
//   out_valid    out_data holds a valid payload
//   out_ready    downstream accepts out_data
//   out_data     payload to downstream (registered)
//   stall_count  saturating count of edges with out_valid=1 and out_ready=0
//   dbg_state    current FSM state (EMPTY=0, BUSY=1, FULL=2), for debug only
module pipeline_skid_stage #(
  parameter int WIDTH    = 32,
  parameter int CNT_W    = 16,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] skid;

  assign dbg_state = state;

  // out_valid and in_ready are written together with state. This keeps them
  // equal to (state != EMPTY) and (state != FULL) without decoding the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      stall_count <= '0;
      if (CLR_DATA) begin
        out_data <= '0;
        skid     <= '0;
      end
    end else begin
      // The counter samples the pre-edge outputs. Flush does not clear it.
      if (out_valid && !out_ready && stall_count != CNT_MAX)
        stall_count <= stall_count + CNT_W'(1);

      if (flush) begin
        // Flush overrides every handshake. Any input offered in this cycle is dropped.
        state     <= EMPTY;
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
        if (CLR_DATA) begin
          out_data <= '0;
          skid     <= '0;
        end
      end else begin
        case (state)
          EMPTY: begin
            if (in_valid) begin
              out_data  <= in_data;
              state     <= BUSY;
              out_valid <= 1'b1;
              in_ready  <= 1'b1;
            end
          end
          BUSY: begin
            if (in_valid && out_ready) begin
              out_data <= in_data;
            end else if (in_valid) begin
              // The output is stalled. Park the new payload in the skid register.
              skid     <= in_data;
              state    <= FULL;
              in_ready <= 1'b0;
            end else if (out_ready) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
          FULL: begin
            // in_ready is 0 here, so in_valid carries no meaning.
            if (out_ready) begin
              out_data <= skid;
              state    <= BUSY;
              in_ready <= 1'b1;
            end
          end
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_skid_stage.sv
module tb_pipeline_skid_stage;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;
  localparam int unsigned STALL_MAX = 65535;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  pipeline_skid_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W), .CLR_DATA(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .stall_count (stall_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds the entries the stage should currently contain, oldest first.
  logic [WIDTH-1:0] exp_q[$];
  int unsigned      m_stall;
  int               checks;
  int               errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
    chk("stall_count", {48'd0, stall_count}, {32'd0, m_stall});
    if (exp_q.size() > 0)
      chk("out_data", {32'd0, out_data}, {32'd0, exp_q[0]});
  endtask

  // ---------------- driver ----------------
  // Inputs are already set by the caller. This task advances one edge,
  // updates the model from those same inputs, and then checks outputs.
  task automatic cycle();
    int unsigned n_before;
    bit          ofire;
    bit          ifire;
    n_before = exp_q.size();
    @(posedge clk);
    if (!reset) begin
      exp_q.delete();
      m_stall = 0;
    end else begin
      if (n_before > 0 && !out_ready && m_stall < STALL_MAX) m_stall++;
      if (flush) begin
        exp_q.delete();
      end else begin
        ofire = (n_before > 0) && out_ready;
        ifire = in_valid && (n_before < 2);
        if (ofire) void'(exp_q.pop_front());
        if (ifire) exp_q.push_back(in_data);
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] nxt_out;
    logic             acc;
    checks  = 0;
    errors  = 0;
    m_stall = 0;
    reset   = 1'b0;
    flush   = 1'b0;
    drive(1'b0, '0, 1'b0);

    // Reset state
    cycle();
    cycle();
    chk("reset_data", {32'd0, out_data}, 64'd0);
    reset = 1'b1;
    #2;

    // Streaming at full rate
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'hA5A5_0000 + WIDTH'(i), 1'b1);
      cycle();
      chk("t1_data", {32'd0, out_data}, {32'd0, 32'hA5A5_0000 + 32'(i)});
      chk("t1_stall", {48'd0, stall_count}, 64'd0);
    end
    drive(1'b0, '0, 1'b1);
    cycle();

    // Backpressure into the skid register
    drive(1'b1, 32'h11, 1'b0);
    cycle();
    drive(1'b1, 32'h22, 1'b0);
    cycle();
    chk("t2_full_ready", {63'd0, in_ready}, 64'd0);
    chk("t2_hold0", {32'd0, out_data}, 64'h11);
    drive(1'b0, '0, 1'b0);
    cycle();
    chk("t2_hold1", {32'd0, out_data}, 64'h11);
    drive(1'b0, '0, 1'b1);
    cycle();
    chk("t2_second", {32'd0, out_data}, 64'h22);
    chk("t2_ready_back", {63'd0, in_ready}, 64'd1);
    cycle();

    // Flush while FULL, with an input offered
    drive(1'b1, 32'h33, 1'b0);
    cycle();
    drive(1'b1, 32'h44, 1'b0);
    cycle();
    flush = 1'b1;
    drive(1'b1, 32'h55, 1'b0);
    cycle();
    flush = 1'b0;
    chk("t3_valid", {63'd0, out_valid}, 64'd0);
    chk("t3_ready", {63'd0, in_ready}, 64'd1);
    chk("t3_clr", {32'd0, out_data}, 64'd0);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_no_output", {63'd0, out_valid}, 64'd0);
    end

    // Stall counter saturation
    drive(1'b1, 32'h66, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0);
    repeat (70000) cycle();
    chk("t4_sat", {48'd0, stall_count}, 64'd65535);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("t4_flush_keep", {48'd0, stall_count}, 64'd65535);

    // Reset while FULL, with an input offered
    drive(1'b1, 32'h77, 1'b0);
    cycle();
    drive(1'b1, 32'h88, 1'b0);
    cycle();
    chk("t6_full", {63'd0, in_ready}, 64'd0);
    reset = 1'b0;
    drive(1'b1, 32'h99, 1'b1);
    cycle();
    reset = 1'b1;
    chk("t6_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_ready", {63'd0, in_ready}, 64'd1);
    chk("t6_stall", {48'd0, stall_count}, 64'd0);
    chk("t6_data", {32'd0, out_data}, 64'd0);

    // Random traffic with an incrementing payload
    cnt     = 32'd1000;
    nxt_out = 32'd1000;
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), cnt, 1'($urandom_range(0, 1)));
      if (exp_q.size() > 0 && out_ready) begin
        chk("t5_seq", {32'd0, out_data}, {32'd0, nxt_out});
        nxt_out++;
      end
      acc = in_valid && (exp_q.size() < 2);
      cycle();
      if (acc) cnt++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
